// File: rtl/lif_pkg.sv
// Shared FSM type and signed saturating arithmetic for the LIF neuron array.
package lif_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  // Signed w-bit bounds carried in 32 bits; w up to 24 keeps every sum exact.
  function automatic logic signed [31:0] smax(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic logic signed [31:0] smin(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int                 w);
    logic signed [31:0] s;
    s = a + b;
    if (s > smax(w)) return smax(w);
    if (s < smin(w)) return smin(w);
    return s;
  endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational sweep step for one neuron: refractory countdown, leak, threshold.
module lif_neuron_update #(
  parameter int DATA_WIDTH = 16,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRACTORY = 4,
  parameter int REF_W      = 3
) (
  input  logic signed [DATA_WIDTH-1:0] i_v,
  input  logic        [REF_W-1:0]      i_ref,
  input  logic signed [DATA_WIDTH-1:0] i_threshold,
  input  logic signed [DATA_WIDTH-1:0] i_v_reset,
  output logic signed [DATA_WIDTH-1:0] o_v_next,
  output logic        [REF_W-1:0]      o_ref_next,
  output logic                         o_spike
);

  logic signed [DATA_WIDTH-1:0] w_vl;

  // Cannot overflow: the subtracted term has the same sign and smaller magnitude.
  assign w_vl = i_v - (i_v >>> LEAK_SHIFT);

  always_comb begin
    o_v_next   = i_v;
    o_ref_next = i_ref;
    o_spike    = 1'b0;
    if (i_ref != '0) begin
      o_ref_next = i_ref - REF_W'(1);
    end else if (w_vl >= i_threshold) begin
      o_spike    = 1'b1;
      o_v_next   = i_v_reset;
      o_ref_next = REF_W'(REFRACTORY);
    end else begin
      o_v_next = w_vl;
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed LIF neuron array: event integration in IDLE, one neuron per
// cycle leak/threshold sweep on tick, single-entry spike index output register.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int  N_NEURONS    = 8,
  parameter int  DATA_WIDTH   = 16,
  parameter int  WEIGHT_WIDTH = 8,
  parameter int  LEAK_SHIFT   = 4,
  parameter int  REFRACTORY   = 4,
  localparam int IDX_W        = $clog2(N_NEURONS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic signed [DATA_WIDTH-1:0]   cfg_threshold,
  input  logic signed [DATA_WIDTH-1:0]   cfg_v_reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic        [IDX_W-1:0]        in_idx,
  input  logic signed [WEIGHT_WIDTH-1:0] in_weight,
  input  logic                           tick,
  output logic                           spk_valid,
  input  logic                           spk_ready,
  output logic        [IDX_W-1:0]        spk_idx,
  output logic                           busy,
  output logic                           overrun,
  input  logic        [IDX_W-1:0]        vmem_sel,
  output logic signed [DATA_WIDTH-1:0]   vmem_out
);

  localparam int               REF_W    = $clog2(REFRACTORY + 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  state_t                       r_state, w_state_next;
  logic signed [DATA_WIDTH-1:0] r_v   [N_NEURONS];
  logic        [REF_W-1:0]      r_ref [N_NEURONS];
  logic        [IDX_W-1:0]      r_ptr;
  logic                         r_pending, r_overrun, r_spk_valid;
  logic        [IDX_W-1:0]      r_spk_idx;
  logic signed [DATA_WIDTH-1:0] r_vmem_out;

  logic                         w_in_ready, w_busy, w_accept, w_int_we, w_start, w_commit;
  logic                         w_in_range, w_sel_range;
  logic signed [DATA_WIDTH-1:0] w_upd_v;
  logic        [REF_W-1:0]      w_upd_ref;
  logic                         w_upd_spike;

  assign w_in_range  = ({1'b0, in_idx}   < (IDX_W + 1)'(N_NEURONS));
  assign w_sel_range = ({1'b0, vmem_sel} < (IDX_W + 1)'(N_NEURONS));
  assign w_accept    = in_valid & w_in_ready;
  assign w_int_we    = w_accept & w_in_range & (r_ref[in_idx] == '0);
  assign w_start     = enable & (r_state == ST_IDLE) & (tick | r_pending);
  // A spiking neuron waits until the output register is free or draining this cycle.
  assign w_commit    = enable & (r_state == ST_SWEEP) & (~w_upd_spike | ~r_spk_valid | spk_ready);

  lif_neuron_update #(
    .DATA_WIDTH (DATA_WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .REFRACTORY (REFRACTORY),
    .REF_W      (REF_W)
  ) u_update (
    .i_v         (r_v[r_ptr]),
    .i_ref       (r_ref[r_ptr]),
    .i_threshold (cfg_threshold),
    .i_v_reset   (cfg_v_reset),
    .o_v_next    (w_upd_v),
    .o_ref_next  (w_upd_ref),
    .o_spike     (w_upd_spike)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_next = ST_SWEEP;
      ST_SWEEP: if (w_commit && (r_ptr == LAST_IDX)) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_in_ready = enable & (r_state == ST_IDLE);
    w_busy     = (r_state == ST_SWEEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_NEURONS; i++) begin
        r_v[i]   <= '0;
        r_ref[i] <= '0;
      end
      r_ptr       <= '0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_spk_valid <= 1'b0;
      r_spk_idx   <= '0;
    end else if (enable) begin
      if (w_int_we)
        r_v[in_idx] <= DATA_WIDTH'(sat_add(32'(r_v[in_idx]), 32'(in_weight), DATA_WIDTH));
      if (w_start) begin
        r_ptr     <= '0;
        r_pending <= 1'b0;
      end
      if (w_commit) begin
        r_v[r_ptr]   <= w_upd_v;
        r_ref[r_ptr] <= w_upd_ref;
        r_ptr        <= r_ptr + IDX_W'(1);
      end
      if ((r_state == ST_SWEEP) && tick) begin
        if (r_pending) r_overrun <= 1'b1;
        else           r_pending <= 1'b1;
      end
      if (w_commit && w_upd_spike) begin
        r_spk_valid <= 1'b1;
        r_spk_idx   <= r_ptr;
      end else if (r_spk_valid && spk_ready) begin
        r_spk_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_vmem_out <= '0;
    else if (w_sel_range) r_vmem_out <= r_v[vmem_sel];
    else                  r_vmem_out <= '0;
  end

  assign in_ready  = w_in_ready;
  assign busy      = w_busy;
  assign spk_valid = r_spk_valid;
  assign spk_idx   = r_spk_idx;
  assign overrun   = r_overrun;
  assign vmem_out  = r_vmem_out;

endmodule
